rsa_crt_decrypt: RTL and testbench

//  RSA decryption engine using the Chinese Remainder Theorem. It recovers plaintext m = C^d mod N, with N = p*q, from

---
 rtl/rsa_crt_decrypt.sv | 190 +++++++++++++++++++
 tb/tb_rsa_crt_decrypt.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rsa_crt_decrypt.sv
// RSA CRT decryption: reduces C mod p and mod q, runs two constant-time modular exponentiations
// in parallel, then recombines with Garner's formula. Latency is fixed and independent of the data.
module rsa_crt_decrypt #(
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     C,
    input  logic [W/2-1:0]   p,
    input  logic [W/2-1:0]   q,
    input  logic [W/2-1:0]   dp,
    input  logic [W/2-1:0]   dq,
    input  logic [W/2-1:0]   qinv,
    output logic [W-1:0]     m,
    output logic             busy,
    output logic             done
);
    localparam int H  = W / 2;
    localparam int BW = $clog2(H);
    localparam logic [BW-1:0] BIT_LAST = BW'(H - 1);

    typedef enum logic [2:0] {IDLE, REDUCE, EXP, HMUL, RECOMB, FIN} state_t;

    state_t         state_reg;
    logic [W-1:0]   c_reg, prod_reg, m_reg;
    logic [H-1:0]   qinv_reg, h_reg;
    logic [BW-1:0]  step_reg, bit_reg;
    logic           phase_reg, busy_reg, done_reg;

    // Index 0 works modulo p, index 1 modulo q.
    logic [H-1:0]   n_reg   [2];
    logic [H-1:0]   e_reg   [2];
    logic [H-1:0]   r_reg   [2];
    logic [H-1:0]   x_reg   [2];
    logic [H+1:0]   acc_reg [2];

    logic [H:0]     red_sh   [2];
    logic [H-1:0]   red_next [2];
    logic [H-1:0]   mm_a     [2];
    logic [H-1:0]   mm_b     [2];
    logic [H+1:0]   mm_next  [2];

    logic           last_step;
    logic [BW-1:0]  bsel, esel;
    logic [H-1:0]   t_diff;
    logic [W-1:0]   prod_next, m_int;

    // One interleaved shift-and-add modular multiplication step; stays below n when inputs are below n.
    function automatic logic [H+1:0] mm_step(input logic [H+1:0] acc, input logic [H-1:0] a,
                                             input logic [H-1:0] n, input logic b);
        logic [H+1:0] t, nn;
        nn = {2'b00, n};
        t  = {acc[H:0], 1'b0};
        if (t >= nn) t = t - nn;
        if (b) t = t + {2'b00, a};
        if (t >= nn) t = t - nn;
        return t;
    endfunction

    assign last_step = (step_reg == BIT_LAST);
    assign bsel      = BIT_LAST - step_reg;
    assign esel      = BIT_LAST - bit_reg;

    // m2 < q < p, so a single add of p brings a negative difference back into range.
    assign t_diff = (x_reg[0] >= x_reg[1]) ? x_reg[0] - x_reg[1]
                                            : x_reg[0] + n_reg[0] - x_reg[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unit
            assign red_sh[gi]   = {r_reg[gi], c_reg[W-1]};
            assign red_next[gi] = H'((red_sh[gi] >= {1'b0, n_reg[gi]}) ?
                                     red_sh[gi] - {1'b0, n_reg[gi]} : red_sh[gi]);
            // In EXP the accumulator is always the left operand: x*x when squaring, x*base when multiplying.
            assign mm_a[gi]     = (state_reg == HMUL) ? qinv_reg : x_reg[gi];
            assign mm_b[gi]     = (state_reg == HMUL) ? t_diff :
                                  (phase_reg ? r_reg[gi] : x_reg[gi]);
            assign mm_next[gi]  = mm_step(acc_reg[gi], mm_a[gi], n_reg[gi], mm_b[gi][bsel]);
        end
    endgenerate

    assign prod_next = {prod_reg[W-2:0], 1'b0} + (h_reg[bsel] ? {{H{1'b0}}, n_reg[1]} : '0);
    assign m_int     = {{H{1'b0}}, x_reg[1]} + prod_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            c_reg     <= '0;
            prod_reg  <= '0;
            m_reg     <= '0;
            qinv_reg  <= '0;
            h_reg     <= '0;
            step_reg  <= '0;
            bit_reg   <= '0;
            phase_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            for (int u = 0; u < 2; u++) begin
                n_reg[u]   <= '0;
                e_reg[u]   <= '0;
                r_reg[u]   <= '0;
                x_reg[u]   <= '0;
                acc_reg[u] <= '0;
            end
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        c_reg     <= C;
                        qinv_reg  <= qinv;
                        n_reg[0]  <= p;
                        n_reg[1]  <= q;
                        e_reg[0]  <= dp;
                        e_reg[1]  <= dq;
                        r_reg[0]  <= '0;
                        r_reg[1]  <= '0;
                        m_reg     <= '0;
                        step_reg  <= '0;
                        phase_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= REDUCE;
                    end
                end
                REDUCE: begin
                    c_reg    <= {c_reg[W-2:0], 1'b0};
                    step_reg <= step_reg + 1'b1;
                    for (int u = 0; u < 2; u++) r_reg[u] <= red_next[u];
                    // W steps are counted as two passes of H steps, phase_reg marking the second.
                    if (last_step) begin
                        step_reg  <= '0;
                        phase_reg <= ~phase_reg;
                        if (phase_reg) begin
                            for (int u = 0; u < 2; u++) begin
                                x_reg[u]   <= H'(1);
                                acc_reg[u] <= '0;
                            end
                            bit_reg   <= '0;
                            phase_reg <= 1'b0;
                            state_reg <= EXP;
                        end
                    end
                end
                EXP: begin
                    step_reg <= step_reg + 1'b1;
                    for (int u = 0; u < 2; u++) acc_reg[u] <= mm_next[u];
                    if (last_step) begin
                        step_reg  <= '0;
                        phase_reg <= ~phase_reg;
                        for (int u = 0; u < 2; u++) begin
                            acc_reg[u] <= '0;
                            if (!phase_reg || e_reg[u][esel]) x_reg[u] <= mm_next[u][H-1:0];
                        end
                        if (phase_reg) begin
                            bit_reg <= bit_reg + 1'b1;
                            if (bit_reg == BIT_LAST) state_reg <= HMUL;
                        end
                    end
                end
                HMUL: begin
                    step_reg   <= step_reg + 1'b1;
                    acc_reg[0] <= mm_next[0];
                    if (last_step) begin
                        step_reg  <= '0;
                        h_reg     <= mm_next[0][H-1:0];
                        prod_reg  <= '0;
                        state_reg <= RECOMB;
                    end
                end
                RECOMB: begin
                    step_reg <= step_reg + 1'b1;
                    prod_reg <= prod_next;
                    if (last_step) begin
                        step_reg  <= '0;
                        m_reg     <= m_int;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= FIN;
                    end
                end
                FIN:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign m    = m_reg;
    assign busy = busy_reg;
    assign done = done_reg;
endmodule

// File: tb/tb_rsa_crt_decrypt.sv
// Directed and randomised checks of rsa_crt_decrypt: results, fixed latency, busy window,
// reset abort, start spamming while busy.
module tb_rsa_crt_decrypt;
    localparam int W = 32;
    localparam int H = W / 2;
    localparam int LAT = 2 * H * H + 4 * H + 1;

    logic           clk = 1'b0;
    logic           rst, start;
    logic [W-1:0]   C;
    logic [H-1:0]   p, q, dp, dq, qinv;
    logic [W-1:0]   m;
    logic           busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rsa_crt_decrypt #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .C(C), .p(p), .q(q),
        .dp(dp), .dq(dq), .qinv(qinv), .m(m), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one decryption, scrambles the operand inputs after acceptance and waits for done.
    task automatic run_op(input string tag, input logic [W-1:0] c_in, input logic [H-1:0] p_in,
                          input logic [H-1:0] q_in, input logic [H-1:0] dp_in,
                          input logic [H-1:0] dq_in, input logic [H-1:0] qi_in,
                          output logic [W-1:0] m_out, output int lat, output int busy_cnt);
        tick();
        C = c_in; p = p_in; q = q_in; dp = dp_in; dq = dq_in; qinv = qi_in;
        start = 1'b1;
        tick();
        start = 1'b0;
        C = $urandom; p = H'($urandom); q = H'($urandom);
        dp = H'($urandom); dq = H'($urandom); qinv = H'($urandom);
        lat = 0;
        busy_cnt = 0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                lat = cyc;
                break;
            end
            tick();
        end
        m_out = m;
        $display("%s: C=%0d p=%0d q=%0d dp=%0d dq=%0d qinv=%0d -> m=%0d latency=%0d busy=%0d",
                 tag, c_in, p_in, q_in, dp_in, dq_in, qi_in, m_out, lat, busy_cnt);
    endtask

    function automatic bit is_prime(input int unsigned n);
        if (n < 2) return 1'b0;
        for (int unsigned d = 2; d * d <= n; d++)
            if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int unsigned rand_prime();
        int unsigned c;
        for (int i = 0; i < 100000; i++) begin
            c = $urandom_range(65535, 3);
            if (is_prime(c)) return c;
        end
        return 3;
    endfunction

    function automatic longint unsigned modexp(input longint unsigned b, input longint unsigned e,
                                               input longint unsigned n);
        longint unsigned r = 1;
        longint unsigned bb = b % n;
        longint unsigned ee = e;
        while (ee > 0) begin
            if (ee[0]) r = (r * bb) % n;
            bb = (bb * bb) % n;
            ee = ee >> 1;
        end
        return r;
    endfunction

    function automatic longint modinv(input longint a, input longint n);
        longint t = 0, nt = 1, r = n, nr = a % n, qq, tmp;
        while (nr != 0) begin
            qq  = r / nr;
            tmp = t - qq * nt; t = nt; nt = tmp;
            tmp = r - qq * nr; r = nr; nr = tmp;
        end
        if (t < 0) t = t + n;
        return t;
    endfunction

    initial begin
        logic [W-1:0] res;
        int lat, bcnt, dcount, first, second;
        longint unsigned pr, qr, nr, m0, cr;
        longint dpr, dqr, qir;

        rst = 1'b1; start = 1'b0;
        C = '0; p = '0; q = '0; dp = '0; dq = '0; qinv = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_m", m, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);

        // T1 textbook key
        run_op("t1", 2790, 61, 53, 53, 49, 38, res, lat, bcnt);
        check("t1_m", res, 65);
        check("t1_latency", lat, LAT);
        check("t1_busy_cycles", bcnt, LAT - 1);
        repeat (5) tick();
        check("t1_m_held", m, 65);
        check("t1_done_pulse", done, 0);

        // T2 trivial ciphertexts
        run_op("t2_zero", 0, 61, 53, 53, 49, 38, res, lat, bcnt);
        check("t2_m_zero", res, 0);
        run_op("t2_one", 1, 61, 53, 53, 49, 38, res, lat, bcnt);
        check("t2_m_one", res, 1);
        run_op("t2_nminus1", 3232, 61, 53, 53, 49, 38, res, lat, bcnt);
        check("t2_m_nminus1", res, 3232);

        // T3 zero exponents
        run_op("t3", 2790, 61, 53, 0, 0, 38, res, lat, bcnt);
        check("t3_m", res, 1);
        check("t3_latency", lat, LAT);

        // T4 reset during an operation
        tick();
        C = 2790; p = 61; q = 53; dp = 53; dq = 49; qinv = 38;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (299) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_busy_after_rst", busy, 0);
        check("t4_m_after_rst", m, 0);
        check("t4_done_after_rst", done, 0);
        dcount = 0;
        for (int i = 0; i < 700; i++) begin
            if (done === 1'b1) dcount++;
            tick();
        end
        check("t4_no_done", dcount, 0);
        $display("t4: reset at cycle 300, done pulses afterwards=%0d", dcount);
        run_op("t4_fresh", 2790, 61, 53, 53, 49, 38, res, lat, bcnt);
        check("t4_m_fresh", res, 65);

        // T5 start held high; C changes while busy
        tick();
        C = 2790; p = 61; q = 53; dp = 53; dq = 49; qinv = 38;
        start = 1'b1;
        tick();
        C = 0;
        first = 0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            if (done === 1'b1) begin
                first = cyc;
                break;
            end
            tick();
        end
        check("t5_latency1", first, LAT);
        check("t5_m1", m, 65);
        $display("t5: first result m=%0d at cycle %0d", m, first);
        second = 0;
        for (int cyc = first + 1; cyc <= first + 2000; cyc++) begin
            tick();
            if (done === 1'b1) begin
                second = cyc;
                break;
            end
        end
        check("t5_gap", second - first, LAT + 1);
        check("t5_m2", m, 0);
        $display("t5: second result m=%0d at cycle %0d", m, second);
        start = 1'b0;

        // T6 random keys: m0 encrypted with e=65537 by the model must decrypt back to m0
        for (int k = 0; k < 20; k++) begin
            pr = rand_prime();
            qr = rand_prime();
            for (int j = 0; j < 100 && pr == qr; j++) qr = rand_prime();
            if (pr < qr) begin
                nr = pr; pr = qr; qr = nr;
            end
            nr  = pr * qr;
            m0  = longint'($urandom) % nr;
            cr  = modexp(m0, 65537, nr);
            dpr = modinv(65537 % longint'(pr - 1), longint'(pr - 1));
            dqr = modinv(65537 % longint'(qr - 1), longint'(qr - 1));
            qir = modinv(longint'(qr), longint'(pr));
            run_op($sformatf("t6_%0d", k), W'(cr), H'(pr), H'(qr), H'(dpr), H'(dqr), H'(qir),
                   res, lat, bcnt);
            check($sformatf("t6_m_%0d", k), res, m0);
            check($sformatf("t6_latency_%0d", k), lat, LAT);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
